// File: rtl/dtu_pkg.sv
// Shared DTU link definitions: reply characters, frame geometry,
// RX/TX state encodings and the frame parity function.
package dtu_pkg;

   localparam logic [7:0] ACK_CHAR = 8'h06;
   localparam logic [7:0] NAK_CHAR = 8'h15;

   localparam int FRAME_DATA_BITS = 8;
   localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

   typedef enum logic [2:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_PARITY,
      R_STOP
   } rx_state_e;

   typedef enum logic [2:0] {
      T_IDLE,
      T_START,
      T_DATA,
      T_PARITY,
      T_STOP
   } tx_state_e;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_par(
      input logic [FRAME_DATA_BITS-1:0] d
   );
      return ^d;
   endfunction

endpackage

// File: rtl/dtu_serial_tx.sv
// OVERSAMPLE-timed framer: start, 8 data LSB first, even parity, stop.
// Ports: clk, rst_n, en, load/data (taken when idle), busy, so (idle high).
module dtu_serial_tx
   import dtu_pkg::*;
#(
   parameter int OVERSAMPLE = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       so
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(OVERSAMPLE - 1);

   tx_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           shr_q, shr_d;
   logic                 so_q, so_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shr_d   = shr_q;
      so_d    = so_q;
      if (en) begin
         if (state_q != T_IDLE) cnt_d = cnt_q + CNT_WIDTH'(1);
         unique case (state_q)
            T_IDLE: begin
               if (load) begin
                  shr_d   = data;
                  cnt_d   = '0;
                  so_d    = 1'b0;
                  state_d = T_START;
               end
            end
            T_START: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  so_d    = shr_q[0];
                  state_d = T_DATA;
               end
            end
            T_DATA: begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  if (idx_q == LAST_BIT) begin
                     idx_d   = '0;
                     so_d    = even_par(shr_q);
                     state_d = T_PARITY;
                  end else begin
                     idx_d = idx_q + 3'd1;
                     so_d  = shr_q[idx_q + 3'd1];
                  end
               end
            end
            T_PARITY: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  so_d    = 1'b1;
                  state_d = T_STOP;
               end
            end
            T_STOP: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = T_IDLE;
               end
            end
            default: state_d = T_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= T_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shr_q   <= '0;
         so_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shr_q   <= shr_d;
         so_q    <= so_d;
      end
   end

   assign busy = (state_q != T_IDLE);
   assign so   = so_q;

endmodule

// File: rtl/dtu_responder.sv
// DTU far-end node: receives a framed byte, holds it behind ready/ack,
// and replies ACK/NAK on tx_so. Ports: rx_si in, rx_po/flags out, tx_so.
module dtu_responder
   import dtu_pkg::*;
#(
   parameter int OVERSAMPLE = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rx_si,
   input  logic       rx_data_ack,
   output logic [7:0] rx_po,
   output logic       rx_ready,
   output logic       rx_error,
   output logic       overrun,
   output logic       rx_busy,
   output logic       tx_so,
   output logic       tx_busy
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(OVERSAMPLE - 1);
   localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'(OVERSAMPLE/2 - 1);

   rx_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           shr_q, shr_d;
   logic                 par_q, par_d;
   logic                 sync1_q, sync2_q, prev_q;
   logic [7:0]           po_q, po_d;
   logic                 ready_q, ready_d;
   logic                 err_q, err_d;
   logic                 ovr_q, ovr_d;
   logic                 pend_q, pend_d;
   logic [7:0]           code_q, code_d;
   logic                 done, bad, tx_load;
   logic                 s;

   assign s       = sync2_q;
   assign tx_load = en & pend_q & ~tx_busy;
   // Stop sample and parity check are folded into the completion decision.
   assign bad     = (even_par(shr_q) ^ par_q) | ~s;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shr_d   = shr_q;
      par_d   = par_q;
      done    = 1'b0;
      if (en) begin
         if (state_q != R_IDLE) cnt_d = cnt_q + CNT_WIDTH'(1);
         unique case (state_q)
            R_IDLE: begin
               if (prev_q & ~s) begin
                  cnt_d   = '0;
                  state_d = R_START;
               end
            end
            R_START: begin
               if (cnt_q == HALF) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = s ? R_IDLE : R_DATA;
               end
            end
            R_DATA: begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  shr_d = {s, shr_q[7:1]};
                  idx_d = idx_q + 3'd1;
                  if (idx_q == LAST_BIT) state_d = R_PARITY;
               end
            end
            R_PARITY: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  par_d   = s;
                  state_d = R_STOP;
               end
            end
            R_STOP: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  done    = 1'b1;
                  state_d = R_IDLE;
               end
            end
            default: state_d = R_IDLE;
         endcase
      end
   end

   always_comb begin
      po_d    = po_q;
      ready_d = ready_q;
      err_d   = err_q;
      ovr_d   = ovr_q;
      pend_d  = pend_q;
      code_d  = code_q;
      if (en) begin
         if (rx_data_ack) begin
            ready_d = 1'b0;
            err_d   = 1'b0;
            ovr_d   = 1'b0;
         end
         if (done) begin
            // An ack in this cycle consumed the old byte: no overrun.
            if (ready_q & ~rx_data_ack) ovr_d = 1'b1;
            // A reply still waiting is about to be overwritten.
            if (pend_q & ~tx_load) ovr_d = 1'b1;
            if (bad) begin
               err_d = 1'b1;
            end else begin
               po_d    = shr_q;
               ready_d = 1'b1;
               err_d   = 1'b0;
            end
            pend_d = 1'b1;
            code_d = bad ? NAK_CHAR : ACK_CHAR;
         end else if (tx_load) begin
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= R_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shr_q   <= '0;
         par_q   <= 1'b0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         po_q    <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
         pend_q  <= 1'b0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shr_q   <= shr_d;
         par_q   <= par_d;
         if (en) begin
            sync1_q <= rx_si;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
         end
         po_q    <= po_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
      end
   end

   dtu_serial_tx #(
      .OVERSAMPLE(OVERSAMPLE),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_tx (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .load (tx_load),
      .data (code_q),
      .busy (tx_busy),
      .so   (tx_so)
   );

   assign rx_po    = po_q;
   assign rx_ready = ready_q;
   assign rx_error = err_q;
   assign overrun  = ovr_q;
   assign rx_busy  = (state_q != R_IDLE);

endmodule

// File: tb/tb_dtu_responder.sv
// Directed bench for dtu_responder: clean/errored frames, false start,
// overrun, ack collision and mid-operation reset, checking the replies.
module tb_dtu_responder;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       rx_si;
   logic       rx_data_ack;
   logic [7:0] rx_po;
   logic       rx_ready;
   logic       rx_error;
   logic       overrun;
   logic       rx_busy;
   logic       tx_so;
   logic       tx_busy;

   int nchk = 0;
   int nerr = 0;

   dtu_responder #(
      .OVERSAMPLE(8),
      .CNT_WIDTH (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .rx_si      (rx_si),
      .rx_data_ack(rx_data_ack),
      .rx_po      (rx_po),
      .rx_ready   (rx_ready),
      .rx_error   (rx_error),
      .overrun    (overrun),
      .rx_busy    (rx_busy),
      .tx_so      (tx_so),
      .tx_busy    (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the last bit is held for last_wait cycles.
   task automatic send_frame(input logic [7:0] d, input logic par,
                             input logic stp, input int last_wait);
      logic [10:0] f;
      f = {stp, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_si = f[i];
         repeat ((i == 10) ? last_wait : 8) @(negedge clk);
      end
   endtask

   task automatic ack_pulse();
      rx_data_ack = 1'b1;
      @(negedge clk);
      rx_data_ack = 1'b0;
   endtask

   // Returns on the first negedge of a reply start bit.
   task automatic wait_tx_low(input string tag);
      int n;
      n = 0;
      while (tx_so !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_start_to"}, 32'(n < 300), 32'd1);
   endtask

   task automatic get_reply(input logic [7:0] exp, input string tag);
      logic [7:0] b;
      logic       s0, p, st;
      wait_tx_low(tag);
      repeat (4) @(negedge clk);
      s0 = tx_so;
      for (int i = 0; i < 8; i++) begin
         repeat (8) @(negedge clk);
         b[i] = tx_so;
      end
      repeat (8) @(negedge clk);
      p = tx_so;
      repeat (8) @(negedge clk);
      st = tx_so;
      repeat (4) @(negedge clk);
      check({tag, "_sbit"}, 32'(s0), 32'd0);
      check({tag, "_byte"}, 32'(b), 32'(exp));
      check({tag, "_par"}, 32'(p), 32'(^exp));
      check({tag, "_stop"}, 32'(st), 32'd1);
   endtask

   initial begin
      rst_n       = 1'b0;
      en          = 1'b1;
      rx_si       = 1'b1;
      rx_data_ack = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_po", 32'(rx_po), 32'h00);
      check("rst_flags", 32'({rx_ready, rx_error, overrun}), 32'd0);
      check("rst_rxbusy", 32'(rx_busy), 32'd0);
      check("rst_txso", 32'(tx_so), 32'd1);
      check("rst_txbusy", 32'(tx_busy), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Clean A9 with exact reply latency.
      send_frame(8'hA9, 1'b0, 1'b1, 7);
      check("a9_ready", 32'(rx_ready), 32'd1);
      check("a9_po", 32'(rx_po), 32'hA9);
      check("a9_err", 32'(rx_error), 32'd0);
      check("a9_txso_early", 32'(tx_so), 32'd1);
      @(negedge clk);
      check("a9_txso_fall", 32'(tx_so), 32'd0);
      get_reply(8'h06, "a9_ack");
      check("a9_txbusy_end", 32'(tx_busy), 32'd0);
      ack_pulse();
      check("a9_acked", 32'(rx_ready), 32'd0);

      // Parity error on 77.
      send_frame(8'h77, 1'b1, 1'b1, 8);
      check("par_err", 32'(rx_error), 32'd1);
      check("par_ready", 32'(rx_ready), 32'd0);
      check("par_po", 32'(rx_po), 32'hA9);
      get_reply(8'h15, "par_nak");
      ack_pulse();
      check("par_acked", 32'(rx_error), 32'd0);

      // False start: three-cycle glitch.
      rx_si = 1'b0;
      repeat (3) @(negedge clk);
      rx_si = 1'b1;
      check("fs_busy", 32'(rx_busy), 32'd1);
      begin
         int n;
         n = 0;
         while (rx_busy !== 1'b0 && n < 4) begin
            @(negedge clk);
            n++;
         end
         check("fs_idle", 32'(rx_busy), 32'd0);
      end
      begin
         logic saw_low;
         saw_low = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (tx_so !== 1'b1) saw_low = 1'b1;
         end
         check("fs_txso", 32'(saw_low), 32'd0);
      end
      check("fs_flags", 32'({rx_ready, rx_error, overrun}), 32'd0);

      // Overrun: two frames back to back, two ACK replies.
      fork
         begin
            send_frame(8'hAA, 1'b0, 1'b1, 8);
            send_frame(8'h10, 1'b1, 1'b1, 8);
         end
         begin
            get_reply(8'h06, "ovr_r1");
            get_reply(8'h06, "ovr_r2");
         end
      join
      check("ovr_po", 32'(rx_po), 32'h10);
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_ready", 32'(rx_ready), 32'd1);
      ack_pulse();
      check("ovr_acked", 32'({rx_ready, rx_error, overrun}), 32'd0);

      // Ack lands in the completion cycle of a second frame.
      send_frame(8'h3C, 1'b0, 1'b1, 8);
      check("col_r1", 32'(rx_ready), 32'd1);
      send_frame(8'hC3, 1'b0, 1'b1, 6);
      ack_pulse();
      check("col_ready", 32'(rx_ready), 32'd1);
      check("col_ovr", 32'(overrun), 32'd0);
      check("col_po", 32'(rx_po), 32'hC3);
      repeat (200) @(negedge clk);

      // Reset during RX data bits.
      rx_si = 1'b0;
      repeat (30) @(negedge clk);
      check("rstrx_busy_pre", 32'(rx_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstrx_busy", 32'(rx_busy), 32'd0);
      check("rstrx_flags", 32'({rx_ready, rx_error, overrun}), 32'd0);
      check("rstrx_po", 32'(rx_po), 32'h00);
      rx_si = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reset during a reply.
      send_frame(8'h5A, 1'b0, 1'b1, 8);
      repeat (20) @(negedge clk);
      check("rsttx_busy_pre", 32'(tx_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rsttx_so", 32'(tx_so), 32'd1);
      check("rsttx_busy", 32'(tx_busy), 32'd0);
      check("rsttx_flags", 32'({rx_ready, rx_error, overrun}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Clean frame after reset.
      send_frame(8'h77, 1'b0, 1'b1, 8);
      check("fin_po", 32'(rx_po), 32'h77);
      check("fin_ready", 32'(rx_ready), 32'd1);
      check("fin_err", 32'(rx_error), 32'd0);
      get_reply(8'h06, "fin_ack");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/dtu_responder.md
Name: dtu_responder

Overview:
- Far-end node of the DTU serial link.
- Receives one character frame on a serial input, checks parity and stop bit, and presents the byte on a parallel output with a ready/ack handshake.
- Answers every completed frame on a serial output: ACK (8'h06) if the frame is clean, NAK (8'h15) if it is not.
- The TX side uses the same frame format the DTU transmitter emits, so the responder can sit directly on the DTU line and drive a return line back to it.

Parameters:
- OVERSAMPLE, 8, clk cycles per serial bit; legal range 4..255; must be even.
- CNT_WIDTH, 8, width of the bit-phase counter; must satisfy 2^CNT_WIDTH > OVERSAMPLE.

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; when 0, all state, counters and outputs hold.
- rx_si  input  1  serial data from the initiator; idle high; asynchronous to clk.
- rx_data_ack  input  1  consumer acknowledge; clears rx_ready, rx_error and overrun.
- rx_po  output  8  last received data byte.
- rx_ready  output  1  a clean frame is held in rx_po.
- rx_error  output  1  the last frame had a parity or stop error.
- overrun  output  1  a frame completed while rx_ready was still set.
- rx_busy  output  1  receive FSM is not in R_IDLE.
- tx_so  output  1  serial reply line; idle high.
- tx_busy  output  1  reply transmitter is not in T_IDLE.

Behaviour:
- Reset values: rx_po=0, rx_ready=0, rx_error=0, overrun=0, rx_busy=0, tx_so=1, tx_busy=0, pending=0, both FSMs in idle.
- Frame format, both directions: start bit (0), 8 data bits LSB first, even parity bit, stop bit (1). Total 11 bits = 11*OVERSAMPLE cycles.
- rx_si passes through a 2-flop synchronizer (resets to 1). Every "sample" below uses the synchronized value.
- RX FSM states: R_IDLE, R_START, R_DATA, R_PARITY, R_STOP.
  - R_IDLE: synchronized 1->0 transition -> R_START; phase counter cleared.
  - R_START: at count OVERSAMPLE/2-1, sample. If 0 -> R_DATA and clear counter. If 1, it was a false start -> R_IDLE with no flags and no reply.
  - R_DATA / R_PARITY / R_STOP: sample each bit at count OVERSAMPLE-1, i.e. at mid-bit. R_DATA takes 8 samples into a shift register; the bit index wraps 7->0 on exit.
  - R_STOP: after the sample, always -> R_IDLE.
- Frame completion, in the cycle after the stop sample:
  - error = (parity of data ^ parity bit) | ~stop bit.
  - Clean frame: rx_po<=data, rx_ready<=1, rx_error<=0.
  - Errored frame: rx_po unchanged, rx_error<=1.
  - If rx_ready was already 1 at completion: overrun<=1 (sticky). For a clean frame rx_po is still overwritten.
  - Reply code ACK or NAK is posted to a one-deep pending register.
- Handshake:
  - rx_data_ack=1 for one cycle clears rx_ready, rx_error and overrun next cycle.
  - If ack and completion fall in the same cycle, completion wins; overrun is not set by that frame.
- TX FSM states: T_IDLE, T_START, T_DATA, T_PARITY, T_STOP.
  - T_IDLE with pending=1: load the reply code, clear pending, drive the start bit on the next cycle.
  - Each bit is held for exactly OVERSAMPLE cycles.
  - After the stop bit -> T_IDLE; tx_so=1.
  - Latency: tx_so falls 2 cycles after the stop-sample cycle when the TX FSM is idle.
- Reply queueing:
  - If pending=1 when a new completion posts, the new code overwrites the old one. The dropped reply sets overrun.
  - The TX FSM never aborts a reply in progress.
- RX and TX run independently; a new frame may be received while a reply is still being sent.
- en=0 mid-frame: everything freezes; the frame resumes when en returns to 1. Frames on rx_si that arrive while en=0 are lost.
- Reset asserted mid-operation: every output returns to its reset value immediately; any partial frame or reply is discarded.

Decomposition:
- dtu_pkg holds:
  - ACK_CHAR=8'h06 and NAK_CHAR=8'h15;
  - FRAME_DATA_BITS=8;
  - the RX and TX state encodings;
  - the parity function.
- One natural sub-module: dtu_serial_tx. It is the OVERSAMPLE-timed framer (load, busy, so) and is instantiated once for the reply path.

Test Plan:
- Clean byte: send 8'hA9 (parity 0, stop 1), OVERSAMPLE=8 -> rx_po=8'hA9, rx_ready=1, rx_error=0, and tx_so carries an 8'h06 frame starting 2 cycles after the stop sample.
- Parity error: send 8'h77 with parity bit 1 -> rx_error=1, rx_ready=0, rx_po unchanged, and an 8'h15 frame is sent.
- False start: a 3-cycle low glitch on rx_si -> rx_busy returns low within 4 cycles; no flags are set and tx_so stays 1.
- Overrun: send 8'hAA and 8'h10 back to back without an ack -> rx_po=8'h10 and overrun=1. Two ACK replies are sent, the second once the first completes. After rx_data_ack, all flags are 0.
- Ack/completion collision: pulse rx_data_ack in the exact completion cycle of a second frame -> rx_ready=1 and overrun=0.
- Reset mid-frame: assert rst_n=0 during the data bits of the RX frame and during a reply -> tx_so=1 and all flags 0 immediately. A subsequent 8'h77 frame is received cleanly.
